// File: rtl/mux2_rr_arbiter.sv
// Two-source round-robin arbiter with packet lock feeding one registered output stage.
// Grant alternates per packet and is held from a packet's first beat through its last beat.
module mux2_rr_arbiter #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  a_last,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  b_last,
  input  logic                  b_valid,
  output logic                  b_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel
);

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic last_grant;
  logic sel_q;
  logic sel_c;
  logic load_en_c;
  logic accept_a_c;
  logic accept_b_c;

  assign load_en_c  = !out_valid || out_ready;
  assign accept_a_c = a_valid && a_ready;
  assign accept_b_c = b_valid && b_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: lock on a non-last first beat, release on the locked side's last beat
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept_a_c && !a_last) begin
          state_nxt = LOCK_A;
        end else if (accept_b_c && !b_last) begin
          state_nxt = LOCK_B;
        end
      end
      LOCK_A: begin
        if (accept_a_c && a_last) begin
          state_nxt = IDLE;
        end
      end
      LOCK_B: begin
        if (accept_b_c && b_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant and handshake outputs; nothing is offered while reset is held
  always_comb begin
    sel_c   = sel_q;
    sel     = 1'b0;
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (state)
      IDLE: begin
        if (a_valid && !b_valid) begin
          sel_c = 1'b0;
        end else if (b_valid && !a_valid) begin
          sel_c = 1'b1;
        end else if (a_valid && b_valid) begin
          sel_c = !last_grant;
        end
      end
      LOCK_A:  sel_c = 1'b0;
      LOCK_B:  sel_c = 1'b1;
      default: sel_c = 1'b0;
    endcase
    if (rst_n) begin
      sel     = sel_c;
      a_ready = load_en_c && !sel_c;
      b_ready = load_en_c && sel_c;
    end
  end

  // Grant history and the one-entry output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      sel_q      <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      sel_q <= sel_c;
      if (accept_a_c) begin
        out_data   <= a_data;
        out_last   <= a_last;
        out_valid  <= 1'b1;
        last_grant <= 1'b0;
      end else if (accept_b_c) begin
        out_data   <= b_data;
        out_last   <= b_last;
        out_valid  <= 1'b1;
        last_grant <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed self-checking bench for mux2_rr_arbiter: reset, round-robin, lock,
// backpressure, reset mid-packet and stalled lock.
module tb_mux2_rr_arbiter;

  localparam int unsigned DATA_WIDTH = 8;

  logic                  clk;
  logic                  rst_n;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  a_last;
  logic                  a_valid;
  logic                  a_ready;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  b_last;
  logic                  b_valid;
  logic                  b_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;
  logic                  sel;

  int checks;
  int errors;

  mux2_rr_arbiter #(.DATA_WIDTH(DATA_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_data(a_data), .a_last(a_last), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_last(b_last), .b_valid(b_valid), .b_ready(b_ready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .sel(sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_data = '0; a_last = 1'b0; a_valid = 1'b0;
    b_data = '0; b_last = 1'b0; b_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    out_ready = 1'b0;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int na;
    int nb;
    checks = 0;
    errors = 0;

    // Reset values
    idle_inputs();
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #3;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_sel", 32'(sel), 0);
    check("rst_a_ready", 32'(a_ready), 0);
    check("rst_b_ready", 32'(b_ready), 0);
    tick();
    rst_n = 1'b1;

    // Single source
    a_valid = 1'b1; a_data = 8'h11; a_last = 1'b1; out_ready = 1'b1;
    #1;
    check("single_a_ready", 32'(a_ready), 1);
    check("single_sel", 32'(sel), 0);
    check("single_b_ready", 32'(b_ready), 0);
    tick();
    a_valid = 1'b0;
    check("single_out_data", 32'(out_data), 'h11);
    check("single_out_last", 32'(out_last), 1);
    check("single_out_valid", 32'(out_valid), 1);
    tick();
    check("single_drain", 32'(out_valid), 0);

    // Tie round-robin: A, B, A, B
    do_reset();
    out_ready = 1'b1;
    na = 0;
    nb = 0;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; a_last = 1'b1; a_data = 8'(8'hA0 + na);
      b_valid = 1'b1; b_last = 1'b1; b_data = 8'(8'hB0 + nb);
      #1;
      check("rr_sel", 32'(sel), 32'(i % 2));
      tick();
      if (i % 2 == 0) begin
        check("rr_out_data", 32'(out_data), 32'(8'hA0 + na));
        na++;
      end else begin
        check("rr_out_data", 32'(out_data), 32'(8'hB0 + nb));
        nb++;
      end
      check("rr_out_valid", 32'(out_valid), 1);
    end
    idle_inputs();
    tick();

    // Packet lock: A sends 3 beats with B valid throughout
    do_reset();
    out_ready = 1'b1;
    b_valid = 1'b1; b_data = 8'hB5; b_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_valid = 1'b1; a_data = 8'(8'h30 + k); a_last = (k == 2);
      #1;
      check("lock_b_ready", 32'(b_ready), 0);
      check("lock_a_ready", 32'(a_ready), 1);
      tick();
      check("lock_out_data", 32'(out_data), 32'(8'h30 + k));
      check("lock_out_last", 32'(out_last), 32'(k == 2));
    end
    a_data = 8'h40; a_last = 1'b1;
    #1;
    check("lock_next_sel", 32'(sel), 1);
    check("lock_next_b_ready", 32'(b_ready), 1);
    tick();
    check("lock_next_out_data", 32'(out_data), 'hB5);
    check("lock_next_out_valid", 32'(out_valid), 1);
    idle_inputs();
    tick();

    // Backpressure
    do_reset();
    out_ready = 1'b1;
    a_valid = 1'b1; a_data = 8'h50; a_last = 1'b1;
    tick();
    check("bp_first", 32'(out_data), 'h50);
    out_ready = 1'b0;
    a_data = 8'h51;
    b_valid = 1'b1; b_data = 8'h60; b_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bp_a_ready", 32'(a_ready), 0);
      check("bp_b_ready", 32'(b_ready), 0);
      tick();
      check("bp_out_data", 32'(out_data), 'h50);
      check("bp_out_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_rel_b_ready", 32'(b_ready), 1);
    tick();
    check("bp_rel_out0", 32'(out_data), 'h60);
    b_valid = 1'b0;
    tick();
    check("bp_rel_out1", 32'(out_data), 'h51);
    check("bp_rel_valid1", 32'(out_valid), 1);
    a_valid = 1'b0;
    tick();
    check("bp_rel_drain", 32'(out_valid), 0);

    // Reset mid-packet
    do_reset();
    out_ready = 1'b1;
    a_valid = 1'b1; a_data = 8'h70; a_last = 1'b0;
    tick();
    a_data = 8'h71;
    b_valid = 1'b1; b_data = 8'h80; b_last = 1'b1;
    #1;
    check("mid_locked_sel", 32'(sel), 0);
    check("mid_locked_b_ready", 32'(b_ready), 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_out_data", 32'(out_data), 0);
    a_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_after_sel", 32'(sel), 1);
    check("mid_after_b_ready", 32'(b_ready), 1);
    tick();
    check("mid_after_out_data", 32'(out_data), 'h80);
    check("mid_after_out_valid", 32'(out_valid), 1);
    idle_inputs();
    tick();

    // Stalled lock
    do_reset();
    out_ready = 1'b1;
    a_valid = 1'b1; a_data = 8'h90; a_last = 1'b0;
    tick();
    check("stall_first", 32'(out_data), 'h90);
    a_valid = 1'b0;
    b_valid = 1'b1; b_data = 8'hC0; b_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_b_ready", 32'(b_ready), 0);
      check("stall_sel", 32'(sel), 0);
      tick();
    end
    check("stall_drained", 32'(out_valid), 0);
    a_valid = 1'b1; a_data = 8'h91; a_last = 1'b1;
    #1;
    check("stall_a_ready", 32'(a_ready), 1);
    tick();
    check("stall_a_last_data", 32'(out_data), 'h91);
    check("stall_a_last_flag", 32'(out_last), 1);
    a_valid = 1'b0;
    #1;
    check("stall_b_sel", 32'(sel), 1);
    check("stall_b_ready_after", 32'(b_ready), 1);
    tick();
    check("stall_b_out_data", 32'(out_data), 'hC0);
    idle_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux2_rr_arbiter.md
# mux2_rr_arbiter

Two-requester round-robin arbiter with packet lock that shares a single downstream stream (router output port or core spike input) between two upstream valid/ready sources. It computes the 2-to-1 select internally, muxes the winning source's data and `last` flag, and registers them in a one-entry output stage. Once a multi-beat packet starts, the grant is held until that packet's final beat. Intended to sit in front of any shared packet channel in the router/core fabric.

## Interface
- `DATA_WIDTH`, 8, payload width per beat.
- `clk`  input  1  single clock, all state on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `a_data`  input  DATA_WIDTH  source A payload.
- `a_last`  input  1  source A final beat of packet.
- `a_valid`  input  1  source A beat available.
- `a_ready`  output  1  source A beat accepted this cycle (when `a_valid`).
- `b_data`, `b_last`, `b_valid`, `b_ready`: same as the A ports, for source B.
- `out_data`  output  DATA_WIDTH  registered payload.
- `out_last`  output  1  registered last flag.
- `out_valid`  output  1  output register holds a beat.
- `out_ready`  input  1  downstream accepts the beat.
- `sel`  output  1  current grant: 0 = A, 1 = B (combinational).

## Operation
- State: FSM {IDLE, LOCK_A, LOCK_B}, `last_grant` (1 bit), output register {`out_data`, `out_last`, `out_valid`}.
- `load_en = !out_valid | out_ready`.
- Grant in IDLE: only A valid → A; only B valid → B; both valid → the side != `last_grant`; neither → `sel` holds its previous value.
- Grant in LOCK_A: A. Grant in LOCK_B: B. The other side is blocked regardless of its valid.
- `a_ready = load_en & (sel == 0)`; `b_ready = load_en & (sel == 1)`. `ready` may depend on `valid`. Valid must not depend on ready.
- Accept of side X occurs when `X_valid & X_ready`. On accept:
  - The output register loads X data/last.
  - `out_valid` ← 1.
  - `last_grant` ← X.
- Transitions:
  - IDLE, accept X with last = 0 → LOCK_X.
  - IDLE, accept with last = 1 → IDLE.
  - LOCK_X, accept X with last = 1 → IDLE.
  - Otherwise the state holds.
- No accept and `out_ready & out_valid` → `out_valid` ← 0; `out_data`/`out_last` are held (don't-care).
- Drain and load in the same cycle: the new beat replaces the old one and `out_valid` stays 1.
- Locked source deasserts valid mid-packet: the lock is held indefinitely and the other source stays blocked (no timeout).
- At most one source is accepted per cycle.

## Timing
- Reset values (async, while `rst_n` = 0):
  - state = IDLE.
  - `last_grant` = 1, so A wins the first tie.
  - `sel` = 0.
  - `out_valid` = 0, `out_data` = 0, `out_last` = 0.
- Reset asserted mid-packet: the lock and any buffered beat are discarded. After release, arbitration restarts from IDLE.
- Latency: a beat accepted at edge N is visible on `out_*` after edge N, i.e. one cycle.
- Throughput: one beat per cycle while `out_ready` = 1.
- Backpressure: `out_valid & !out_ready` → both readies are 0, and `out_data`/`out_last` are stable until the beat is taken.
- The `sel` change from an IDLE tie takes effect in the same cycle the valids are presented. Round-robin alternation is applied per packet, not per beat.

## Test plan
- **Reset and single source:** reset, then `a_valid` = 1, `a_data` = 0x11, `a_last` = 1, `out_ready` = 1.
  - `a_ready` = 1, `sel` = 0.
  - The next cycle gives `out_data` = 0x11, `out_last` = 1, `out_valid` = 1.
  - All outputs read 0 during reset.
- **Tie round-robin:** both sources continuously present single-beat packets (A = 0xA0.., B = 0xB0..), `out_ready` = 1.
  - Output sequence A, B, A, B; first beat from A.
- **Packet lock:** A sends 3 beats (last on the 3rd) while B is valid throughout.
  - B is blocked: `b_ready` = 0 for all 3 beats.
  - B's beat follows immediately after A's last beat, with no idle cycle.
- **Backpressure:** hold `out_ready` = 0 for 4 cycles with `out_valid` = 1.
  - `out_data` is stable.
  - `a_ready` = `b_ready` = 0.
  - Release gives 1 beat/cycle resumption with no loss or duplication.
- **Reset mid-packet:** assert `rst_n` = 0 after beat 1 of a 3-beat A packet, then release with B valid.
  - `out_valid` = 0 during reset.
  - After release B is granted; the LOCK_A state is gone.
- **Stalled lock:** A sends 1 non-last beat, then drops valid for 5 cycles while B is valid.
  - `b_ready` stays 0 and `sel` = 0.
  - A's last beat then releases the lock and B goes next.
